// File: rtl/cdiv_pkg.sv
// Shared types and constants for the complex-divider operand path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cdiv_pkg;

    localparam int CDIV_NUM_OPERANDS = 4;
    localparam int CDIV_WIDTH        = 64;

    typedef logic [CDIV_NUM_OPERANDS-1:0][CDIV_WIDTH-1:0] cdiv_operands_t;

    // Operand slot order inside a bundle: (a + jb) / (c + jd)
    typedef enum logic [1:0] {
        OP_A = 2'd0,
        OP_B = 2'd1,
        OP_C = 2'd2,
        OP_D = 2'd3
    } cdiv_op_e;

    // True for +0.0 and -0.0 (exponent and mantissa all zero, sign ignored)
    function automatic logic fp64_is_zero(input logic [63:0] w);
        return (w[62:0] == 63'd0);
    endfunction

endpackage

// File: rtl/cdiv_operand_packer.sv
// Packs a scalar FP64 word stream into {a,b,c,d} bundles for complex_div (optional den_zero_o: CDIV_PACK_ZERO_DEN_EN).
// Latency: bundle valid 1 cycle after its last word is accepted (when the output bank is free).
// Backpressure: gather bank + output bank give 1 word/cycle; word_ready_o drops only when both are full.
module cdiv_operand_packer
    import cdiv_pkg::*;
#(
    parameter int NUM_OPERANDS = CDIV_NUM_OPERANDS,
    parameter int WIDTH        = CDIV_WIDTH
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 flush_i,
    input  logic                                 word_valid_i,
    output logic                                 word_ready_o,
    input  logic [WIDTH-1:0]                     word_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [NUM_OPERANDS-1:0][WIDTH-1:0]   operands_o,
    output logic                                 busy_o
`ifdef CDIV_PACK_ZERO_DEN_EN
    ,
    output logic                                 den_zero_o
`endif
);

    localparam int IDX_W = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPERANDS - 1);

    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic                               gather_full_q, gather_full_d;
    logic                               out_vld_q, out_vld_d;
    logic [NUM_OPERANDS-1:0][WIDTH-1:0] gather_q, gather_d;
    logic [NUM_OPERANDS-1:0][WIDTH-1:0] out_q, out_d;
    logic [NUM_OPERANDS-1:0][WIDTH-1:0] direct_bundle;
    logic                               word_acc;
    logic                               out_free;
    logic                               out_load;

    // Last word bypasses the gather bank so a bundle can load the same cycle it completes
    always_comb begin
        for (int k = 0; k < NUM_OPERANDS - 1; k++) begin
            direct_bundle[k] = gather_q[k];
        end
        direct_bundle[NUM_OPERANDS-1] = word_i;
    end

    // Next-state for index, gather bank, output bank and their flags
    always_comb begin
        idx_d         = idx_q;
        gather_full_d = gather_full_q;
        out_vld_d     = out_vld_q;
        gather_d      = gather_q;
        out_d         = out_q;
        out_load      = 1'b0;
        // Ready looks only at registered state, never at out_ready_i
        word_acc      = word_valid_i & ~gather_full_q;
        out_free      = ~out_vld_q | out_ready_i;

        if (flush_i) begin
            idx_d         = '0;
            gather_full_d = 1'b0;
            out_vld_d     = 1'b0;
        end else begin
            if (out_vld_q && out_ready_i) begin
                out_vld_d = 1'b0;
            end
            // A parked bundle moves out as soon as the output bank frees up
            if (gather_full_q && out_free) begin
                out_d         = gather_q;
                out_vld_d     = 1'b1;
                gather_full_d = 1'b0;
                out_load      = 1'b1;
            end
            if (word_acc) begin
                gather_d[idx_q] = word_i;
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if (out_free) begin
                        out_d     = direct_bundle;
                        out_vld_d = 1'b1;
                        out_load  = 1'b1;
                    end else begin
                        gather_full_d = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q         <= '0;
            gather_full_q <= 1'b0;
            out_vld_q     <= 1'b0;
            gather_q      <= '0;
            out_q         <= '0;
        end else begin
            idx_q         <= idx_d;
            gather_full_q <= gather_full_d;
            out_vld_q     <= out_vld_d;
            gather_q      <= gather_d;
            out_q         <= out_d;
        end
    end

`ifdef CDIV_PACK_ZERO_DEN_EN
    if (NUM_OPERANDS < 4) begin : g_too_few_operands
        $error("cdiv_operand_packer: den_zero_o needs NUM_OPERANDS >= 4");
    end

    logic den_zero_q, den_zero_d;

    // Zero-divisor flag travels with the output bank contents
    always_comb begin
        den_zero_d = den_zero_q;
        if (flush_i) begin
            den_zero_d = 1'b0;
        end else if (out_load) begin
            den_zero_d = fp64_is_zero(out_d[int'(OP_C)]) & fp64_is_zero(out_d[int'(OP_D)]);
        end
    end

    // Zero-divisor flag register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            den_zero_q <= 1'b0;
        end else begin
            den_zero_q <= den_zero_d;
        end
    end

    assign den_zero_o = den_zero_q;
`endif

    assign word_ready_o = ~gather_full_q;
    assign out_valid_o  = out_vld_q;
    assign operands_o   = out_q;
    assign busy_o       = out_vld_q | gather_full_q | (idx_q != '0);

endmodule

// File: tb/tb_cdiv_operand_packer.sv
// Self-checking bench for cdiv_operand_packer: scoreboard of expected bundles.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// Optional den_zero_o checks are compiled in with CDIV_PACK_ZERO_DEN_EN.
module tb_cdiv_operand_packer;
    import cdiv_pkg::*;

    localparam logic [63:0] F_7   = 64'h401C_0000_0000_0000;
    localparam logic [63:0] F_2   = 64'h4000_0000_0000_0000;
    localparam logic [63:0] F_1   = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] F_PZ  = 64'h0000_0000_0000_0000;
    localparam logic [63:0] F_NZ  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] F_QN  = 64'h7FF8_0000_0000_0000;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           flush_i;
    logic           word_valid_i;
    logic           word_ready_o;
    logic [63:0]    word_i;
    logic           out_valid_o;
    logic           out_ready_i;
    cdiv_operands_t operands_o;
    logic           busy_o;
`ifdef CDIV_PACK_ZERO_DEN_EN
    logic           den_zero_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cdiv_operands_t sb[$];
    cdiv_operands_t gm;
    int             gcnt = 0;

    always #5 clk_i = ~clk_i;

    cdiv_operand_packer dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .word_valid_i (word_valid_i),
        .word_ready_o (word_ready_o),
        .word_i       (word_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .operands_o   (operands_o),
`ifdef CDIV_PACK_ZERO_DEN_EN
        .den_zero_o   (den_zero_o),
`endif
        .busy_o       (busy_o)
    );

    // Drive one cycle from a falling edge; record accepted words into the
    // scoreboard and report whether a bundle handshake happens this cycle.
    task automatic drive_cycle(input logic fl, input logic wv, input logic [63:0] w,
                               input logic rdy, output logic got, output cdiv_operands_t data);
        flush_i      = fl;
        word_valid_i = wv;
        word_i       = w;
        out_ready_i  = rdy;
        #1;
        got  = out_valid_o & rdy;
        data = operands_o;
        if (fl) begin
            gcnt = 0;
        end else if (wv && word_ready_o) begin
            gm[gcnt] = w;
            gcnt++;
            if (gcnt == 4) begin
                sb.push_back(gm);
                gcnt = 0;
            end
        end
        @(negedge clk_i);
    endtask

    function automatic logic [63:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return F_NZ;
            1:       return F_QN;
            2:       return F_PZ;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0; flush_i = 1'b0; word_valid_i = 1'b0; word_i = '0; out_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if (out_valid_o !== 1'b0 || operands_o !== '0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: valid=%b busy=%b ops=%h, want 0/0/0", out_valid_o, busy_o, operands_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (word_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_word_ready: got %b want 1", word_ready_o);
        end
        n_checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b busy=%b want 0/0", out_valid_o, busy_o);
        end
        n_checks++;
        if (operands_o !== '0) begin
            n_fail++;
            $display("FAIL reset_operands: got %h want 0", operands_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0]    w[4];
        cdiv_operands_t exp_c, exp, d;
        logic           got;
        w[0] = F_7; w[1] = F_2; w[2] = F_1; w[3] = F_2;
        for (int i = 0; i < 4; i++) exp_c[i] = w[i];
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (word_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_word_ready[%0d]: got %b want 1", i, word_ready_o);
            end
            drive_cycle(1'b0, 1'b1, w[i], 1'b1, got, d);
            n_checks++;
            if (got !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_early_valid[%0d]: got %b want 0", i, got);
            end
        end
        n_checks++;
        if (out_valid_o !== 1'b1 || operands_o !== exp_c) begin
            n_fail++;
            $display("FAIL b2b_bundle: valid=%b ops=%h want 1 ops=%h", out_valid_o, operands_o, exp_c);
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b1, got, d);
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        n_checks++;
        if (got !== 1'b1 || d !== exp) begin
            n_fail++;
            $display("FAIL b2b_consume: got=%b ops=%h want 1 ops=%h", got, d, exp);
        end
        n_checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: valid=%b busy=%b want 0/0", out_valid_o, busy_o);
        end
    endtask

    task automatic test_stall();
        cdiv_operands_t b1, b2, d;
        logic           got;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (word_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_accept[%0d]: word_ready=%b want 1", i, word_ready_o);
            end
            drive_cycle(1'b0, 1'b1, {32'hA5A5_0000 + i, 32'h0123_4567 * (i + 1)}, 1'b0, got, d);
        end
        b1 = (sb.size() > 0) ? sb[0] : '1;
        b2 = (sb.size() > 1) ? sb[1] : '1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (word_ready_o !== 1'b0 || out_valid_o !== 1'b1 || operands_o !== b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: wrdy=%b valid=%b ops=%h want 0/1 ops=%h",
                         i, word_ready_o, out_valid_o, operands_o, b1);
            end
            drive_cycle(1'b0, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, got, d);
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b1, got, d);
        if (sb.size() > 0) void'(sb.pop_front());
        n_checks++;
        if (got !== 1'b1 || d !== b1) begin
            n_fail++;
            $display("FAIL stall_bundle1: got=%b ops=%h want 1 ops=%h", got, d, b1);
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b1, got, d);
        if (sb.size() > 0) void'(sb.pop_front());
        n_checks++;
        if (got !== 1'b1 || d !== b2) begin
            n_fail++;
            $display("FAIL stall_bundle2: got=%b ops=%h want 1 ops=%h", got, d, b2);
        end
        n_checks++;
        if (out_valid_o !== 1'b0 || word_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drain: valid=%b wrdy=%b busy=%b want 0/1/0", out_valid_o, word_ready_o, busy_o);
        end
    endtask

    task automatic test_flush();
        cdiv_operands_t exp_c, exp, d;
        logic           got;
        logic           seen;
        drive_cycle(1'b0, 1'b1, 64'h1111_1111_1111_1111, 1'b1, got, d);
        drive_cycle(1'b0, 1'b1, 64'h2222_2222_2222_2222, 1'b1, got, d);
        drive_cycle(1'b1, 1'b1, 64'h3333_3333_3333_3333, 1'b1, got, d);
        n_checks++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy: busy=%b valid=%b want 0/0", busy_o, out_valid_o);
        end
        exp_c[0] = F_1; exp_c[1] = F_NZ; exp_c[2] = F_QN; exp_c[3] = F_7;
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, exp_c[i], 1'b1, got, d);
        seen = 1'b0;
        for (int t = 0; t < 5 && !seen; t++) begin
            drive_cycle(1'b0, 1'b0, '0, 1'b1, got, d);
            if (got) begin
                seen = 1'b1;
                exp  = (sb.size() > 0) ? sb.pop_front() : '1;
                n_checks++;
                if (d !== exp_c || d !== exp) begin
                    n_fail++;
                    $display("FAIL flush_clean_bundle: ops=%h want %h", d, exp_c);
                end
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL flush_timeout: got no bundle, want 1");
        end
    endtask

    task automatic test_async_reset();
        cdiv_operands_t exp_c, d;
        logic           got;
        for (int i = 0; i < 7; i++) drive_cycle(1'b0, 1'b1, {32'hC0DE_0000 + i, 32'h0}, 1'b0, got, d);
        n_checks++;
        if (out_valid_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_setup: valid=%b busy=%b want 1/1", out_valid_o, busy_o);
        end
        word_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0 || operands_o !== '0 || busy_o !== 1'b0 || word_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_immediate: valid=%b busy=%b wrdy=%b ops=%h want 0/0/1/0",
                     out_valid_o, busy_o, word_ready_o, operands_o);
        end
        sb.delete();
        gcnt = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        exp_c[0] = F_2; exp_c[1] = F_PZ; exp_c[2] = F_NZ; exp_c[3] = F_1;
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, exp_c[i], 1'b1, got, d);
        drive_cycle(1'b0, 1'b0, '0, 1'b1, got, d);
        if (sb.size() > 0) void'(sb.pop_front());
        n_checks++;
        if (got !== 1'b1 || d !== exp_c) begin
            n_fail++;
            $display("FAIL arst_first_bundle: got=%b ops=%h want 1 ops=%h", got, d, exp_c);
        end
    endtask

    task automatic test_random();
        cdiv_operands_t d, exp, prev_d, cur_d;
        logic           got, wv, rdy, prev_hold, cur_v;
        logic [63:0]    w;
        int             sent, recv;
        sent = 0; recv = 0; prev_hold = 1'b0; prev_d = '0;
        for (int cyc = 0; cyc < 40000 && recv < 1000; cyc++) begin
            wv  = (sent < 4000) && ($urandom_range(0, 3) != 0);
            w   = rand_word();
            rdy = 1'($urandom_range(0, 1));
            cur_v = out_valid_o;
            cur_d = operands_o;
            if (prev_hold) begin
                n_checks++;
                if (cur_v !== 1'b1 || cur_d !== prev_d) begin
                    n_fail++;
                    $display("FAIL rand_stable: valid=%b ops=%h want 1 ops=%h", cur_v, cur_d, prev_d);
                end
            end
            if (wv && word_ready_o) sent++;
            drive_cycle(1'b0, wv, w, rdy, got, d);
            prev_hold = cur_v & ~rdy;
            prev_d    = cur_d;
            if (got) begin
                recv++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_order: unexpected bundle %h, want none", d);
                end else begin
                    exp = sb.pop_front();
                    if (d !== exp) begin
                        n_fail++;
                        $display("FAIL rand_data[%0d]: ops=%h want %h", recv, d, exp);
                    end
                end
            end
        end
        n_checks++;
        if (recv != 1000 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL rand_count: bundles=%0d left=%0d want 1000/0", recv, sb.size());
        end
    endtask

`ifdef CDIV_PACK_ZERO_DEN_EN
    task automatic test_den_zero();
        cdiv_operands_t d;
        logic           got;
        logic [63:0]    w[8];
        logic           exp_z[2];
        w[0] = F_1; w[1] = F_2; w[2] = F_PZ; w[3] = F_NZ;
        w[4] = F_1; w[5] = F_2; w[6] = F_PZ; w[7] = F_2;
        exp_z[0] = 1'b1; exp_z[1] = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, w[4*b+i], 1'b1, got, d);
            word_valid_i = 1'b0;
            n_checks++;
            if (out_valid_o !== 1'b1 || den_zero_o !== exp_z[b]) begin
                n_fail++;
                $display("FAIL den_zero[%0d]: valid=%b den_zero=%b want 1/%b", b, out_valid_o, den_zero_o, exp_z[b]);
            end
            drive_cycle(1'b0, 1'b0, '0, 1'b1, got, d);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_flush();
        test_async_reset();
`ifdef CDIV_PACK_ZERO_DEN_EN
        test_den_zero();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
